// File: rtl/i2c_scan_pkg.sv
// Shared types and constants for the I2C scan sequencer.
// State encoding, channel-index width helper and default timings.
package i2c_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_SETTLE,
    S_REQ,
    S_WAIT,
    S_STORE,
    S_NEXT,
    S_IVL
  } state_e;

  localparam int TMR_W = 32;

  localparam int DEF_TRIG_CYC    = 8;
  localparam int DEF_SETTLE_CYC  = 64;
  localparam int DEF_TIMEOUT_CYC = 4096;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with zero flag.
// Shared by trigger, settle, timeout and interval phases.
module scan_timer
  import i2c_scan_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         resetG,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetG) begin
    if (!resetG) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_scan_sequencer.sv
// Multi-channel trigger/settle/read sweep controller
// in front of an I2C byte engine, with a result bank.
module i2c_scan_sequencer
  import i2c_scan_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 7,
  parameter int unsigned BASE_ADDR   = 'h40,
  parameter int          TRIG_CYC    = DEF_TRIG_CYC,
  parameter int          SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int          IVL_W       = 24,
  parameter int          CH_W        = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              resetG,
  input  logic              start,
  input  logic              cont_mode,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [IVL_W-1:0]  interval,
  input  logic              abort,
  output logic              busy,
  output logic              sweep_done,
  output logic              exttrigger,
  output logic              i2c_req,
  output logic [ADDR_W-1:0] i2c_addr,
  input  logic              i2c_ack,
  input  logic              i2c_done,
  input  logic              i2c_nack,
  input  logic [DATA_W-1:0] i2c_rdata,
  input  logic [CH_W-1:0]   rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0] valid,
  output logic [NUM_CH-1:0] err
);

  localparam logic [TMR_W-1:0] TRIG_LD =
    TMR_W'(TRIG_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD =
    TMR_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] TO_LD =
    TMR_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              cont_q, cont_d;
  logic              abort_q, abort_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] bank_q [NUM_CH];
  logic [DATA_W-1:0] bank_d [NUM_CH];

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;

  logic              first_hit, next_hit;
  logic [CH_W-1:0]   first_idx, next_idx;

  scan_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .resetG   (resetG),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Lowest set bit of the live mask; lowest set bit above ch_q in the latched mask.
  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    next_hit  = 1'b0;
    next_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        first_hit = 1'b1;
        first_idx = CH_W'(i);
      end
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_hit = 1'b1;
        next_idx = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    valid_d  = valid_q;
    err_d    = err_q;
    cont_d   = cont_q;
    abort_d  = abort_q;
    done_d   = 1'b0;
    bank_d   = bank_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          mask_d = ch_en;
          cont_d = cont_mode;
          if (first_hit) begin
            ch_d     = first_idx;
            state_d  = S_TRIG;
            tmr_load = 1'b1;
            tmr_val  = TRIG_LD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_TRIG: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tmr_zero) begin
          state_d  = S_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tmr_zero) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (i2c_ack) begin
          state_d  = S_WAIT;
          abort_d  = abort;
          tmr_load = 1'b1;
          tmr_val  = TO_LD;
        end else if (abort) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        abort_d = abort_q | abort;
        // A done arriving on the expiry cycle still wins over the timeout.
        if (i2c_done) begin
          state_d = S_STORE;
          if (i2c_nack) begin
            err_d[ch_q] = 1'b1;
          end else begin
            bank_d[ch_q]  = i2c_rdata;
            valid_d[ch_q] = 1'b1;
            err_d[ch_q]   = 1'b0;
          end
        end else if (tmr_zero) begin
          state_d     = S_STORE;
          err_d[ch_q] = 1'b1;
        end
      end
      S_STORE: begin
        state_d = (abort_q || abort) ? S_IDLE : S_NEXT;
      end
      S_NEXT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (next_hit) begin
          ch_d     = next_idx;
          state_d  = S_TRIG;
          tmr_load = 1'b1;
          tmr_val  = TRIG_LD;
        end else begin
          done_d = 1'b1;
          cont_d = cont_mode;
          if (cont_mode) begin
            state_d  = S_IVL;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(interval);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_IVL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tmr_zero) begin
          mask_d = ch_en;
          if (first_hit) begin
            ch_d     = first_idx;
            state_d  = S_TRIG;
            tmr_load = 1'b1;
            tmr_val  = TRIG_LD;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetG) begin
    if (!resetG) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      mask_q  <= '0;
      valid_q <= '0;
      err_q   <= '0;
      cont_q  <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cont_q  <= cont_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_sel) < NUM_CH) begin
      rd_data = bank_q[rd_sel];
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign exttrigger = (state_q == S_TRIG);
  assign i2c_req    = (state_q == S_REQ);
  assign i2c_addr   = i2c_req ?
    ADDR_W'(BASE_ADDR + 32'(ch_q)) : '0;
  assign sweep_done = done_q;
  assign valid      = valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_i2c_scan_sequencer.sv
// Directed bench for i2c_scan_sequencer: vector table of
// single sweeps plus hand sequences for abort/reset/continuous.
module tb_i2c_scan_sequencer;

  localparam int TRIG_CYC    = 8;
  localparam int TIMEOUT_CYC = 4096;

  logic        clk;
  logic        resetG;
  logic        start;
  logic        cont_mode;
  logic [3:0]  ch_en;
  logic [23:0] interval;
  logic        abort;
  logic        busy;
  logic        sweep_done;
  logic        exttrigger;
  logic        i2c_req;
  logic [6:0]  i2c_addr;
  logic        i2c_ack;
  logic        i2c_done;
  logic        i2c_nack;
  logic [15:0] i2c_rdata;
  logic [1:0]  rd_sel;
  logic [15:0] rd_data;
  logic [3:0]  valid;
  logic [3:0]  err;

  i2c_scan_sequencer dut (
    .clk        (clk),
    .resetG     (resetG),
    .start      (start),
    .cont_mode  (cont_mode),
    .ch_en      (ch_en),
    .interval   (interval),
    .abort      (abort),
    .busy       (busy),
    .sweep_done (sweep_done),
    .exttrigger (exttrigger),
    .i2c_req    (i2c_req),
    .i2c_addr   (i2c_addr),
    .i2c_ack    (i2c_ack),
    .i2c_done   (i2c_done),
    .i2c_nack   (i2c_nack),
    .i2c_rdata  (i2c_rdata),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .valid      (valid),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Engine model: ack 2 cycles after req, done ~100 cycles later.
  logic [3:0] nack_mask = '0;
  logic [3:0] hang_mask = '0;
  int ack_log[$];

  initial begin
    int k;
    i2c_ack   = 1'b0;
    i2c_done  = 1'b0;
    i2c_nack  = 1'b0;
    i2c_rdata = '0;
    forever begin
      @(negedge clk);
      if (resetG && i2c_req) begin
        k = int'(i2c_addr) - 'h40;
        if (k < 0 || k > 3) k = 0;
        @(negedge clk);
        @(negedge clk);
        i2c_ack = 1'b1;
        ack_log.push_back(cyc);
        @(negedge clk);
        i2c_ack = 1'b0;
        repeat (98) @(negedge clk);
        if (!hang_mask[k]) begin
          i2c_done  = 1'b1;
          i2c_nack  = nack_mask[k];
          i2c_rdata = 16'h1230 + 16'(k);
          @(negedge clk);
          i2c_done = 1'b0;
          i2c_nack = 1'b0;
        end
      end
    end
  end

  // Passive monitor, running totals only.
  int         trig_rise[$];
  int         done_log[$];
  logic [6:0] req_log[$];
  int         bad_w = 0;
  int         addr_unstable = 0;
  int         err_rise[4];

  initial begin
    logic       p_trig, p_req;
    logic [6:0] p_addr;
    logic [3:0] p_err;
    int         wcnt;
    p_trig = 0; p_req = 0; p_addr = 0; p_err = 0; wcnt = 0;
    for (int i = 0; i < 4; i++) err_rise[i] = 0;
    forever begin
      @(negedge clk);
      if (exttrigger && !p_trig) begin
        trig_rise.push_back(cyc);
        wcnt = 1;
      end else if (exttrigger) begin
        wcnt++;
      end
      if (!exttrigger && p_trig && wcnt != TRIG_CYC) bad_w++;
      if (i2c_req && !p_req) req_log.push_back(i2c_addr);
      if (i2c_req && p_req && i2c_addr != p_addr) addr_unstable++;
      if (sweep_done) done_log.push_back(cyc);
      for (int i = 0; i < 4; i++)
        if (err[i] && !p_err[i]) err_rise[i] = cyc;
      p_trig = exttrigger;
      p_req  = i2c_req;
      p_addr = i2c_addr;
      p_err  = err;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetG = 1'b0;
    repeat (2) @(negedge clk);
    resetG = 1'b1;
  endtask

  task automatic pulse_start(input logic [3:0] en, input logic c);
    @(negedge clk);
    ch_en     = en;
    cont_mode = c;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit,
                           input string nm);
    int n = 0;
    while (done_log.size() < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(done_log.size() >= target), 1);
  endtask

  task automatic wait_idle(input int limit, input string nm);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(busy), 0);
  endtask

  task automatic wait_ack(input int target, input int limit,
                          input string nm);
    int n = 0;
    while (ack_log.size() < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(ack_log.size() >= target), 1);
  endtask

  typedef struct {
    logic             rst;
    logic [3:0]       en;
    logic [3:0]       nack;
    logic [3:0]       hang;
    logic [3:0]       exp_valid;
    logic [3:0]       exp_err;
    logic [3:0][15:0] exp_bank;
  } vec_t;

  localparam int NV = 6;
  vec_t tv[NV];

  initial begin
    int tb0, rb0, db0, bw0, ua0, a0;
    logic [3:0] bits;
    logic       ord;
    int         k;

    tv[0] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0,
              {16'h1233, 16'h1232, 16'h1231, 16'h1230}};
    tv[1] = '{1'b0, 4'hF, 4'h4, 4'h8, 4'hF, 4'hC,
              {16'h1233, 16'h1232, 16'h1231, 16'h1230}};
    tv[2] = '{1'b1, 4'hA, 4'h0, 4'h0, 4'hA, 4'h0,
              {16'h1233, 16'h0000, 16'h1231, 16'h0000}};
    tv[3] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'hA, 4'h0,
              {16'h1233, 16'h0000, 16'h1231, 16'h0000}};
    tv[4] = '{1'b0, 4'h8, 4'h8, 4'h0, 4'hA, 4'h8,
              {16'h1233, 16'h0000, 16'h1231, 16'h0000}};
    tv[5] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'hB, 4'h8,
              {16'h1233, 16'h0000, 16'h1231, 16'h1230}};

    resetG    = 1'b0;
    start     = 1'b0;
    cont_mode = 1'b0;
    ch_en     = '0;
    interval  = 24'd500;
    abort     = 1'b0;
    rd_sel    = '0;

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({busy, sweep_done, exttrigger, i2c_req, i2c_addr,
             valid, err, rd_data}), 0);
    resetG = 1'b1;

    for (int r = 0; r < NV; r++) begin
      if (tv[r].rst) do_reset();
      nack_mask = tv[r].nack;
      hang_mask = tv[r].hang;
      tb0 = trig_rise.size();
      rb0 = req_log.size();
      db0 = done_log.size();
      bw0 = bad_w;
      ua0 = addr_unstable;
      pulse_start(tv[r].en, 1'b0);
      wait_done(db0 + 1, 20000, $sformatf("r%0d_sweep_end", r));
      repeat (20) @(negedge clk);
      chk($sformatf("r%0d_valid", r), 32'(valid), 32'(tv[r].exp_valid));
      chk($sformatf("r%0d_err", r), 32'(err), 32'(tv[r].exp_err));
      for (int i = 0; i < 4; i++) begin
        rd_sel = 2'(i);
        #1;
        chk($sformatf("r%0d_bank%0d", r, i), 32'(rd_data),
            32'(tv[r].exp_bank[i]));
      end
      bits = '0;
      ord  = 1'b1;
      for (int i = rb0; i < req_log.size(); i++) begin
        k = int'(req_log[i]) - 'h40;
        if (k < 0 || k > 3) ord = 1'b0;
        else bits[k] = 1'b1;
        if (i > rb0 && req_log[i] <= req_log[i-1]) ord = 1'b0;
      end
      chk($sformatf("r%0d_req_addrs", r), 32'(bits), 32'(tv[r].en));
      chk($sformatf("r%0d_req_order", r), 32'(ord), 1);
      chk($sformatf("r%0d_req_cnt", r), req_log.size() - rb0,
          $countones(tv[r].en));
      chk($sformatf("r%0d_trig_cnt", r), trig_rise.size() - tb0,
          $countones(tv[r].en));
      chk($sformatf("r%0d_done_cnt", r), done_log.size() - db0, 1);
      chk($sformatf("r%0d_trig_width", r), bad_w - bw0, 0);
      chk($sformatf("r%0d_addr_stable", r), addr_unstable - ua0, 0);
      chk($sformatf("r%0d_busy", r), 32'(busy), 0);
      if (tv[r].hang != 4'h0)
        chk($sformatf("r%0d_timeout_lat", r),
            err_rise[3] - ack_log[$], TIMEOUT_CYC + 1);
    end
    nack_mask = '0;
    hang_mask = '0;

    // Continuous mode with interval 500, then cont_mode cleared mid-sweep.
    do_reset();
    tb0 = trig_rise.size();
    db0 = done_log.size();
    interval = 24'd500;
    pulse_start(4'h1, 1'b1);
    wait_done(db0 + 1, 2000, "cont_first_done");
    begin
      int n = 0;
      while (trig_rise.size() < tb0 + 2 && n < 1000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("cont_second_trig_seen", 32'(trig_rise.size() >= tb0 + 2), 1);
    if (trig_rise.size() >= tb0 + 2 && done_log.size() > db0)
      chk("cont_interval_gap", trig_rise[tb0+1] - done_log[db0], 501);
    cont_mode = 1'b0;
    wait_done(db0 + 2, 2000, "cont_second_done");
    repeat (700) @(negedge clk);
    chk("cont_stop_done_cnt", done_log.size() - db0, 2);
    chk("cont_stop_trig_cnt", trig_rise.size() - tb0, 2);
    chk("cont_stop_busy", 32'(busy), 0);

    // Abort during SETTLE.
    do_reset();
    tb0 = trig_rise.size();
    rb0 = req_log.size();
    db0 = done_log.size();
    pulse_start(4'h1, 1'b0);
    repeat (15) @(negedge clk);
    chk("settle_state", 32'({busy, exttrigger}), 32'(2'b10));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("settle_abort_idle", 32'({busy, exttrigger}), 0);
    repeat (200) @(negedge clk);
    chk("settle_abort_no_req", req_log.size() - rb0, 0);
    chk("settle_abort_no_done", done_log.size() - db0, 0);

    // Abort during WAIT: result still stored, then idle.
    do_reset();
    tb0 = trig_rise.size();
    db0 = done_log.size();
    a0  = ack_log.size();
    pulse_start(4'h4, 1'b0);
    wait_ack(a0 + 1, 300, "wait_abort_ack");
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("wait_abort_still_busy", 32'(busy), 1);
    wait_idle(300, "wait_abort_idle");
    repeat (200) @(negedge clk);
    rd_sel = 2'd2;
    #1;
    chk("wait_abort_bank2", 32'(rd_data), 32'h1232);
    chk("wait_abort_valid", 32'(valid), 32'h4);
    chk("wait_abort_no_done", done_log.size() - db0, 0);
    chk("wait_abort_trig_cnt", trig_rise.size() - tb0, 1);

    // Reset during WAIT; the late done must not touch the bank.
    a0 = ack_log.size();
    pulse_start(4'h1, 1'b0);
    wait_ack(a0 + 1, 300, "rst_wait_ack");
    repeat (10) @(negedge clk);
    chk("rst_wait_busy_before", 32'(busy), 1);
    resetG = 1'b0;
    #1;
    chk("rst_async_outputs",
        32'({busy, sweep_done, exttrigger, i2c_req, i2c_addr,
             valid, err, rd_data}), 0);
    @(negedge clk);
    resetG = 1'b1;
    repeat (150) @(negedge clk);
    rd_sel = 2'd0;
    #1;
    chk("rst_stray_bank0", 32'(rd_data), 0);
    chk("rst_stray_valid", 32'(valid), 0);
    chk("rst_stray_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_scan_sequencer.md
Name: i2c_scan_sequencer

Overview:
Parametrised sweep controller that sequences repeated measurements across NUM_CH I2C sensor channels.
- Per channel: pulses an external trigger, waits a settle time, issues a read request to the existing I2C byte engine, then stores the 16-bit result.
- Adds over the single-shot measure/done flow: channel masking, continuous sweep mode with programmable interval, NACK/timeout error capture, and a per-channel result bank.
- Sits between the system control logic and the I2C master engine.

Parameters:
NUM_CH, 4, number of sensor channels (1..16)
DATA_W, 16, result width per channel
ADDR_W, 7, I2C device address width
BASE_ADDR, 7'h40, address of channel 0; channel k uses (BASE_ADDR + k) mod 2^ADDR_W
TRIG_CYC, 8, exttrigger high time in clk cycles (>=1)
SETTLE_CYC, 64, wait after trigger falls before request (>=0)
TIMEOUT_CYC, 4096, maximum cycles from request accept to i2c_done
IVL_W, 24, width of the interval input

Ports:
clk  in  1  system clock
resetG  in  1  asynchronous active-low reset
start  in  1  sweep start pulse; ignored while busy
cont_mode  in  1  1 = re-sweep after interval; sampled on start and at each sweep end
ch_en  in  NUM_CH  channel enable mask, sampled on start
interval  in  IVL_W  idle cycles between sweeps in continuous mode
abort  in  1  stop request
busy  out  1  high in any state other than IDLE
sweep_done  out  1  one-cycle pulse at end of each sweep
exttrigger  out  1  sensor conversion trigger
i2c_req  out  1  transaction request to the I2C engine
i2c_addr  out  ADDR_W  device address, valid while i2c_req is high
i2c_ack  in  1  engine accepted the request
i2c_done  in  1  one-cycle pulse when the transaction ends
i2c_nack  in  1  qualified by i2c_done; 1 = device did not acknowledge
i2c_rdata  in  DATA_W  read data, qualified by i2c_done
rd_sel  in  CH_W  result bank read select; CH_W = max(1, clog2(NUM_CH))
rd_data  out  DATA_W  stored result for rd_sel (combinational read)
valid  out  NUM_CH  per-channel "result ever stored"
err  out  NUM_CH  per-channel "last attempt failed"

Behaviour:
- Reset (resetG=0, asynchronous):
  - state IDLE; all outputs 0; result bank 0; valid=0, err=0; channel index 0.
- States: IDLE, TRIG, SETTLE, REQ, WAIT, STORE, NEXT, INTERVAL.
- IDLE:
  - start=1 latches ch_en and cont_mode.
  - Then selects the lowest enabled channel and goes to TRIG next cycle.
  - If the latched mask is 0, it pulses sweep_done the next cycle and stays in IDLE.
- TRIG: exttrigger=1 for exactly TRIG_CYC cycles, then SETTLE.
- SETTLE: SETTLE_CYC cycles with exttrigger=0, then REQ. SETTLE_CYC=0 passes through in one cycle.
- REQ:
  - i2c_req=1 and i2c_addr held stable until the cycle i2c_ack=1.
  - i2c_req drops the following cycle; state goes to WAIT.
  - The timeout counter starts at ack.
- WAIT:
  - i2c_done=1 with i2c_nack=0: latch i2c_rdata into bank[ch], set valid[ch], clear err[ch].
  - i2c_done=1 with i2c_nack=1: set err[ch]; bank and valid unchanged.
  - No i2c_done within TIMEOUT_CYC cycles of ack: set err[ch]; bank unchanged.
  - The register update takes effect in STORE, one cycle after done or timeout. i2c_done in the same cycle as timeout expiry counts as done.
- NEXT:
  - Advances to the next higher enabled channel and goes to TRIG.
  - After the last enabled channel: sweep_done pulses for one cycle.
  - Then: cont_mode=1 goes to INTERVAL; otherwise IDLE.
- INTERVAL:
  - Waits `interval` cycles (0 means none), re-latches ch_en, and restarts from the lowest enabled channel.
  - A zero mask at that point ends the sweep: sweep_done pulses and state goes to IDLE.
- abort:
  - In TRIG, SETTLE, NEXT or INTERVAL: go to IDLE next cycle and drop exttrigger. No sweep_done pulse.
  - In REQ before ack: drop i2c_req and go to IDLE.
  - After ack: latched and honoured after STORE. The result of the in-flight transaction is still stored.
- Ignored inputs: i2c_done outside WAIT; start while busy.
- Wrap: channel addresses wrap modulo 2^ADDR_W.
- Read port: rd_sel >= NUM_CH returns 0.

Decomposition:
- Package i2c_scan_pkg holds:
  - state enum;
  - CH_W function/localparam;
  - default timing constants.
- One sub-module, scan_timer: a loadable down-counter with a zero flag, reused for the TRIG, SETTLE, WAIT-timeout and INTERVAL durations.
- Channel selection is a priority find-next over the mask, implemented in the top level.

Test Plan:
- Setup: NUM_CH=4, ch_en=4'b1111, start, engine model acks after 2 cycles, done after 100 with rdata=16'h1230+k -> four exttrigger pulses of TRIG_CYC; addresses 0x40..0x43; bank={0x1230..0x1233}; valid=4'hF, err=0; exactly one sweep_done.
- ch_en=4'b1010 -> only addresses 0x41 and 0x43 requested; valid=4'b1010.
- Channel 2 returns nack=1, channel 3 never returns done -> err=4'b1100; bank[2], bank[3] unchanged; timeout fires at TIMEOUT_CYC after ack; sweep still completes.
- cont_mode=1, interval=500 -> second sweep's first exttrigger rises 500+1 cycles after the first sweep_done; clearing cont_mode mid-sweep ends operation after the current sweep.
- abort during SETTLE -> IDLE next cycle, no i2c_req issued, no sweep_done. Abort during WAIT -> data still stored, then IDLE.
- resetG asserted during WAIT -> all outputs 0 immediately; a later stray i2c_done does not alter the bank.
